// File: rtl/axi_sram_burst.sv
// AXI4 subordinate SRAM/ROM with FIXED/INCR/WRAP bursts, byte strobes and an optional read-only mode.
// Optional 4 KB boundary check on INCR bursts: define AXI_SRAM_4K_CHECK_EN.
package amba_axi_pkg;
  typedef struct packed {
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic        awready;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        buser;
    logic        bvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        ruser;
    logic        rvalid;
  } s_axi_miso_t;
endpackage

module axi_sram_burst #(
  parameter int    MEM_WORDS = 4096,
  parameter bit    READ_ONLY = 1'b0,
  parameter string INIT_FILE = ""
) (
  input  logic                       clk,
  input  logic                       rst,
  input  amba_axi_pkg::s_axi_mosi_t  axi_mosi,
  output amba_axi_pkg::s_axi_miso_t  axi_miso,
  output logic [1:0]                 dbg_state_o
);
  localparam int         AW          = $clog2(MEM_WORDS);
  localparam logic [1:0] B_FIXED     = 2'd0;
  localparam logic [1:0] B_INCR      = 2'd1;
  localparam logic [1:0] B_WRAP      = 2'd2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, RD, WR, BRESP} state_e;
  state_e state_q, state_d;

  logic [3:0]    id_q;
  logic [AW-1:0] waddr_q;
  logic [7:0]    cnt_q;
  logic [7:0]    fcnt_q;
  logic          fdone_q;
  logic [1:0]    burst_q;
  logic [3:0]    wmask_q;
  logic          err_q;
  logic          rvalid_q;
  logic          last_was_rd_q;
  logic [31:0]   mem_rdata_q;
  logic [31:0]   mem [MEM_WORDS];

  logic          both, rd_last_hs, arready, awready, ar_hs, aw_hs, fetch, w_hs;
  logic [3:0]    g_id;
  logic [31:0]   g_addr;
  logic [7:0]    g_len;
  logic [1:0]    g_burst_raw, g_burst;
  logic          g_wrap_ok, g_oor, g_4k, g_err;
  logic [AW-1:0] nxt_addr;
  logic          unused_bits;

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
  always_comb begin
    both       = axi_mosi.arvalid && axi_mosi.awvalid;
    rd_last_hs = (state_q == RD) && rvalid_q && axi_mosi.rready && (cnt_q == 8'd0);
    arready    = !rst && (((state_q == IDLE) && !(both && last_was_rd_q)) ||
                          (rd_last_hs && !axi_mosi.awvalid));
    awready    = !rst && (state_q == IDLE) && !(both && !last_was_rd_q);
    ar_hs      = arready && axi_mosi.arvalid;
    aw_hs      = awready && axi_mosi.awvalid;
    fetch      = (state_q == RD) && !fdone_q && (!rvalid_q || axi_mosi.rready);
    w_hs       = (state_q == WR) && axi_mosi.wvalid;
    state_d    = state_q;
    case (state_q)
      IDLE:    if (ar_hs) state_d = RD; else if (aw_hs) state_d = WR;
      RD:      if (rd_last_hs) state_d = ar_hs ? RD : IDLE;
      WR:      if (w_hs && (cnt_q == 8'd0)) state_d = BRESP;
      BRESP:   if (axi_mosi.bready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    g_id        = ar_hs ? axi_mosi.arid    : axi_mosi.awid;
    g_addr      = ar_hs ? axi_mosi.araddr  : axi_mosi.awaddr;
    g_len       = ar_hs ? axi_mosi.arlen   : axi_mosi.awlen;
    g_burst_raw = ar_hs ? axi_mosi.arburst : axi_mosi.awburst;
    g_wrap_ok   = (g_len == 8'd1) || (g_len == 8'd3) || (g_len == 8'd7) || (g_len == 8'd15);
    // Unsupported WRAP lengths and the reserved encoding degrade to INCR.
    if (g_burst_raw == B_FIXED)                g_burst = B_FIXED;
    else if (g_burst_raw == B_WRAP && g_wrap_ok) g_burst = B_WRAP;
    else                                       g_burst = B_INCR;
    g_oor = |g_addr[31:AW+2];
`ifdef AXI_SRAM_4K_CHECK_EN
    g_4k = (g_burst == B_INCR) &&
           (({2'b00, g_addr[11:0]} + {3'b000, ({1'b0, g_len} + 9'd1), 2'b00}) > 14'd4096);
`else
    g_4k = 1'b0;
`endif
    g_err = g_oor || g_4k || (aw_hs && READ_ONLY);
    case (burst_q)
      B_FIXED: nxt_addr = waddr_q;
      B_WRAP:  nxt_addr = (waddr_q & ~AW'(wmask_q)) | ((waddr_q + AW'(1)) & AW'(wmask_q));
      default: nxt_addr = waddr_q + AW'(1);
    endcase
    unused_bits = ^{axi_mosi.awsize, axi_mosi.arsize, axi_mosi.wlast, g_addr[1:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      id_q          <= '0;
      waddr_q       <= '0;
      cnt_q         <= '0;
      fcnt_q        <= '0;
      fdone_q       <= 1'b0;
      burst_q       <= B_INCR;
      wmask_q       <= '0;
      err_q         <= 1'b0;
      rvalid_q      <= 1'b0;
      last_was_rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fetch) begin
        waddr_q  <= nxt_addr;
        fcnt_q   <= fcnt_q - 8'd1;
        rvalid_q <= 1'b1;
        if (fcnt_q == 8'd0) fdone_q <= 1'b1;
      end else if (rvalid_q && axi_mosi.rready) begin
        rvalid_q <= 1'b0;
      end
      if (rvalid_q && axi_mosi.rready) cnt_q <= cnt_q - 8'd1;
      if (w_hs) begin
        waddr_q <= nxt_addr;
        cnt_q   <= cnt_q - 8'd1;
      end
      // A grant overrides the tail of a finishing read burst.
      if (ar_hs || aw_hs) begin
        last_was_rd_q <= ar_hs;
        id_q          <= g_id;
        waddr_q       <= g_addr[AW+1:2];
        cnt_q         <= g_len;
        fcnt_q        <= g_len;
        fdone_q       <= 1'b0;
        burst_q       <= g_burst;
        wmask_q       <= g_len[3:0];
        err_q         <= g_err;
        rvalid_q      <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && !err_q) begin
      for (int b = 0; b < 4; b++) begin
        if (axi_mosi.wstrb[b]) mem[waddr_q][8*b +: 8] <= axi_mosi.wdata[8*b +: 8];
      end
    end
    if (fetch) mem_rdata_q <= mem[waddr_q];
  end

  always_comb begin
    axi_miso         = '0;
    axi_miso.arready = arready;
    axi_miso.awready = awready;
    axi_miso.wready  = (state_q == WR);
    axi_miso.bvalid  = (state_q == BRESP);
    axi_miso.bid     = id_q;
    axi_miso.bresp   = ((state_q == BRESP) && err_q) ? RESP_SLVERR : RESP_OKAY;
    axi_miso.rvalid  = rvalid_q;
    axi_miso.rid     = id_q;
    axi_miso.rdata   = (rvalid_q && !err_q) ? mem_rdata_q : 32'd0;
    axi_miso.rresp   = (rvalid_q && err_q) ? RESP_SLVERR : RESP_OKAY;
    axi_miso.rlast   = rvalid_q && (cnt_q == 8'd0);
  end

  assign dbg_state_o = state_q;
endmodule
